mmc3_scanline_irq: RTL and testbench
====================================

Name: mmc3_scanline_irq

Overview:
- Scanline IRQ generator for MMC3-class mappers (#004/#118/#189 family); it drives the top-level `irq` pin.
- It watches PPU A12, filters out the fast A12 toggles caused by 8x16 sprite fetches, and counts scanlines with an 8-bit down-counter.
- When the counter reaches zero and the IRQ is enabled, it asserts an active-low interrupt.
- It runs in the CPU M2 domain. The mapper register decoder feeds it one-cycle write strobes.

Parameters:
- FILTER_M2, 3: minimum number of consecutive M2 cycles that synchronized A12 must be low before a rising edge counts as a clock.
- NEW_BEHAVIOUR, 1: 1 = IRQ fires whenever the counter value after a clock is 0; 0 = IRQ fires only when a decrement from 1 reaches 0, or when a reload loads 0 (old MMC3 revision).

Ports:
- m2  input  1  CPU M2 clock; all state is updated on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- ppu_a12  input  1  raw PPU address bit 12; asynchronous to m2.
- reg_we  input  1  one-m2-cycle write strobe for an IRQ register.
- reg_sel  input  2  0=$C000 latch, 1=$C001 reload, 2=$E000 disable/acknowledge, 3=$E001 enable.
- reg_data  input  8  CPU write data; used only when reg_sel=0.
- irq  output  1  active-low interrupt request; 0 = asserted.
- counter_dbg  output  8  current counter value, for debug and verification.

Behaviour:
- Reset (asynchronous, active-high) clears all state:
  - latch = 0, counter = 0, reload_flag = 0, enabled = 0, pending = 0.
  - low_cnt = 0, both sync stages = 0.
  - Outputs: irq = 1, counter_dbg = 0.
  - Releasing reset mid-frame simply resumes with the cleared state.
- A12 synchronizer:
  - Two-flop synchronizer gives a12_s. a12_prev holds a12_s delayed one cycle.
- Low filter:
  - low_cnt is a saturating counter of width clog2(FILTER_M2+1).
  - It increments while a12_s = 0 and clears to 0 while a12_s = 1.
- Clock event (a12_clk):
  - Fires when a12_prev = 0, a12_s = 1 and low_cnt >= FILTER_M2, using the low_cnt value from before its clear.
  - The raw input is therefore seen 3 m2 cycles after it rises.
  - A rise after fewer than FILTER_M2 low cycles is ignored completely: no counter change.
- Counter update on a12_clk:
  - If counter == 0 or reload_flag = 1: counter <= latch and reload_flag <= 0.
  - Otherwise: counter <= counter - 1.
  - Only a reload can produce 0xFF; the counter never wraps below 0.
- IRQ trigger on a12_clk:
  - NEW_BEHAVIOUR=1: if the new counter value == 0 and enabled = 1, set pending.
  - NEW_BEHAVIOUR=0: set pending only if the new value == 0, enabled = 1, and either the old value was 1 or reload_flag was set.
  - With latch = 0 and NEW_BEHAVIOUR=1, every a12_clk sets pending.
- Register writes (take effect on the m2 edge carrying reg_we):
  - reg_sel 0: latch <= reg_data.
  - reg_sel 1: counter <= 0, reload_flag <= 1.
  - reg_sel 2: enabled <= 0, pending <= 0.
  - reg_sel 3: enabled <= 1; does not change pending.
- irq output:
  - irq = ~pending, registered; it goes low 1 cycle after the a12_clk cycle.
  - pending stays set until a reg_sel 2 write or reset.
  - Further clock events do not clear it.
- Simultaneous events in the same cycle:
  - Reload write + a12_clk: the write wins. Result is counter = 0, reload_flag = 1, the edge is discarded, and pending is unchanged.
  - Disable write + a12_clk that would set pending: the disable wins, so pending = 0 and enabled = 0. The counter still updates from that edge.
  - Latch write + a12_clk reload: the reload uses the old latch value.
  - Enable write + a12_clk that reaches 0: the enable is not yet visible, so pending is not set.
- counter_dbg mirrors the counter register, with no added latency.

Test Plan:
- Reset check: assert reset mid-operation with pending = 1 -> irq = 1 immediately (asynchronous), counter_dbg = 0. After release, the first qualifying A12 rise loads the latch (0).
- Basic count: write latch = 3, reload, enable; then apply 4 qualifying A12 pulses (low 8 cycles, high 4 cycles each).
  - counter_dbg reads 3, 2, 1, 0.
  - irq goes low 4 m2 cycles after the raw rise of the 4th pulse.
  - Write $E000 -> irq = 1 on the next cycle.
- Filter rejection: with A12 low for only 2 cycles before each rise, toggle it 10 times -> counter_dbg unchanged. Next rise after 3 low cycles -> counter decrements by 1.
- Latch = 0 with NEW_BEHAVIOUR=1: every qualifying rise keeps the counter at 0 and keeps irq asserted after one acknowledge write. With NEW_BEHAVIOUR=0, after the first reload, no further IRQs occur.
- Collisions:
  - $C001 write in the same cycle as a12_clk with counter = 5 -> counter = 0, reload_flag = 1; the next clock loads the latch.
  - $E000 write in the same cycle as a decrement to 0 -> irq stays 1, counter = 0.
- Reload value: latch = 0xFF, reload, then 1 clock -> counter_dbg = 0xFF. After 255 more clocks -> counter = 0 and irq asserts (enabled = 1).

Source files
------------

// File: rtl/mmc3_scanline_irq.sv
`default_nettype none
// ============================================================================
// Module   : mmc3_scanline_irq
// Brief    : MMC3-class scanline IRQ. Filters PPU A12 and counts scanlines
//            with an 8-bit reloadable down-counter. Active-low IRQ output.
// Revision : 1.0 - initial release
// ============================================================================
module mmc3_scanline_irq #(
    parameter int FILTER_M2     = 3,
    parameter int NEW_BEHAVIOUR = 1
) (
    input  logic       m2,
    input  logic       reset,
    input  logic       ppu_a12,
    input  logic       reg_we,
    input  logic [1:0] reg_sel,
    input  logic [7:0] reg_data,
    output logic       irq,
    output logic [7:0] counter_dbg
);

    localparam int c_low_w = (FILTER_M2 < 1) ? 1 : $clog2(FILTER_M2 + 1);
    localparam logic [c_low_w-1:0] c_low_max = c_low_w'(FILTER_M2);

    localparam logic [1:0] c_sel_latch   = 2'd0;
    localparam logic [1:0] c_sel_reload  = 2'd1;
    localparam logic [1:0] c_sel_disable = 2'd2;
    localparam logic [1:0] c_sel_enable  = 2'd3;

    logic               r_sync1;
    logic               r_a12_s;
    logic               r_a12_prev;
    logic [c_low_w-1:0] r_low_cnt;
    logic [7:0]         r_latch;
    logic [7:0]         r_counter;
    logic               r_reload_flag;
    logic               r_enabled;
    logic               r_pending;
    logic               r_irq;

    logic               w_a12_clk;
    logic               w_take_clk;
    logic               w_fire;
    logic [7:0]         w_clk_counter;
    logic [c_low_w-1:0] w_low_cnt_nxt;
    logic [7:0]         w_latch_nxt;
    logic [7:0]         w_counter_nxt;
    logic               w_reload_nxt;
    logic               w_enabled_nxt;
    logic               w_pending_nxt;

    // Qualification uses the low count accumulated before this cycle's clear.
    assign w_a12_clk     = !r_a12_prev && r_a12_s && (r_low_cnt >= c_low_max);
    assign w_take_clk    = w_a12_clk && !(reg_we && (reg_sel == c_sel_reload));
    assign w_clk_counter = ((r_counter == 8'd0) || r_reload_flag) ? r_latch
                                                                  : (r_counter - 8'd1);

    generate
        if (NEW_BEHAVIOUR != 0) begin : g_new_irq
            assign w_fire = w_take_clk && r_enabled && (w_clk_counter == 8'd0);
        end else begin : g_old_irq
            assign w_fire = w_take_clk && r_enabled && (w_clk_counter == 8'd0)
                            && ((r_counter == 8'd1) || r_reload_flag);
        end
    endgenerate

    always_comb begin
        w_low_cnt_nxt = r_low_cnt;
        w_latch_nxt   = r_latch;
        w_counter_nxt = r_counter;
        w_reload_nxt  = r_reload_flag;
        w_enabled_nxt = r_enabled;
        w_pending_nxt = r_pending;

        if (r_a12_s) begin
            w_low_cnt_nxt = '0;
        end else if (r_low_cnt != c_low_max) begin
            w_low_cnt_nxt = r_low_cnt + 1'b1;
        end

        if (w_take_clk) begin
            w_counter_nxt = w_clk_counter;
            w_reload_nxt  = 1'b0;
        end
        if (w_fire) begin
            w_pending_nxt = 1'b1;
        end

        // Register writes are applied last so they override the clock event.
        if (reg_we) begin
            case (reg_sel)
                c_sel_latch: begin
                    w_latch_nxt = reg_data;
                end
                c_sel_reload: begin
                    w_counter_nxt = 8'd0;
                    w_reload_nxt  = 1'b1;
                end
                c_sel_disable: begin
                    w_enabled_nxt = 1'b0;
                    w_pending_nxt = 1'b0;
                end
                c_sel_enable: begin
                    w_enabled_nxt = 1'b1;
                end
                default: begin
                    w_latch_nxt = r_latch;
                end
            endcase
        end
    end

    always_ff @(posedge m2 or posedge reset) begin
        if (reset) begin
            r_sync1       <= 1'b0;
            r_a12_s       <= 1'b0;
            r_a12_prev    <= 1'b0;
            r_low_cnt     <= '0;
            r_latch       <= 8'd0;
            r_counter     <= 8'd0;
            r_reload_flag <= 1'b0;
            r_enabled     <= 1'b0;
            r_pending     <= 1'b0;
            r_irq         <= 1'b1;
        end else begin
            r_sync1       <= ppu_a12;
            r_a12_s       <= r_sync1;
            r_a12_prev    <= r_a12_s;
            r_low_cnt     <= w_low_cnt_nxt;
            r_latch       <= w_latch_nxt;
            r_counter     <= w_counter_nxt;
            r_reload_flag <= w_reload_nxt;
            r_enabled     <= w_enabled_nxt;
            r_pending     <= w_pending_nxt;
            r_irq         <= ~r_pending;
        end
    end

    assign irq         = r_irq;
    assign counter_dbg = r_counter;

endmodule
`default_nettype wire

// File: tb/tb_mmc3_scanline_irq.sv
`default_nettype none
// ============================================================================
// Module   : tb_mmc3_scanline_irq
// Brief    : Directed bench for mmc3_scanline_irq (new and old IRQ revisions).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mmc3_scanline_irq;

    logic       m2 = 1'b0;
    logic       reset;
    logic       ppu_a12;
    logic       reg_we;
    logic [1:0] reg_sel;
    logic [7:0] reg_data;
    logic       irq;
    logic [7:0] counter_dbg;
    logic       irq_old;
    logic [7:0] counter_old;

    int n_checks = 0;
    int n_err    = 0;

    always #5 m2 = ~m2;

    mmc3_scanline_irq #(.FILTER_M2(3), .NEW_BEHAVIOUR(1)) dut (
        .m2(m2), .reset(reset), .ppu_a12(ppu_a12), .reg_we(reg_we),
        .reg_sel(reg_sel), .reg_data(reg_data), .irq(irq), .counter_dbg(counter_dbg)
    );

    mmc3_scanline_irq #(.FILTER_M2(3), .NEW_BEHAVIOUR(0)) dut_old (
        .m2(m2), .reset(reset), .ppu_a12(ppu_a12), .reg_we(reg_we),
        .reg_sel(reg_sel), .reg_data(reg_data), .irq(irq_old), .counter_dbg(counter_old)
    );

    typedef struct {
        int         kind;     // 0 = register write, 1 = A12 pulse train
        logic [1:0] sel;
        logic [7:0] data;
        int         low;
        int         high;
        int         reps;
        logic [7:0] exp_cnt;
        logic       exp_irq;
        logic       exp_irqo;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input int kind, input logic [1:0] sel, input logic [7:0] data,
                       input int low, input int high, input int reps,
                       input logic [7:0] exp_cnt, input logic exp_irq, input logic exp_irqo);
        vec_t v;
        v.kind = kind; v.sel = sel; v.data = data; v.low = low; v.high = high;
        v.reps = reps; v.exp_cnt = exp_cnt; v.exp_irq = exp_irq; v.exp_irqo = exp_irqo;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge m2);
        #1;
    endtask

    task automatic wr(input logic [1:0] sel, input logic [7:0] data);
        reg_we = 1'b1; reg_sel = sel; reg_data = data;
        tick();
        reg_we = 1'b0;
        tick();
    endtask

    task automatic pulse(input int low, input int high);
        ppu_a12 = 1'b0;
        repeat (low) tick();
        ppu_a12 = 1'b1;
        repeat (high) tick();
    endtask

    // Strobe lands in the cycle where the synchronized rise qualifies.
    task automatic collide(input logic [1:0] sel, input logic [7:0] data);
        ppu_a12 = 1'b0;
        repeat (8) tick();
        ppu_a12 = 1'b1;
        tick();
        tick();
        reg_we = 1'b1; reg_sel = sel; reg_data = data;
        tick();
        reg_we = 1'b0;
        tick();
        tick();
    endtask

    task automatic chk_all(input string nm, input logic [7:0] c, input logic i, input logic io);
        chk({nm, " cnt"}, {24'd0, counter_dbg}, {24'd0, c});
        chk({nm, " irq"}, {31'd0, irq}, {31'd0, i});
        chk({nm, " cnt_old"}, {24'd0, counter_old}, {24'd0, c});
        chk({nm, " irq_old"}, {31'd0, irq_old}, {31'd0, io});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; ppu_a12 = 1'b0; reg_we = 1'b0; reg_sel = 2'd0; reg_data = 8'd0;
        repeat (3) tick();
        chk_all("reset", 8'd0, 1'b1, 1'b1);
        reset = 1'b0;
        tick();

        //  kind sel data low high reps  cnt  irq irqo
        add(0, 2'd0, 8'd3, 0, 0, 1, 8'd3 - 8'd3, 1, 1);
        add(0, 2'd1, 8'd0, 0, 0, 1, 8'd0, 1, 1);
        add(0, 2'd3, 8'd0, 0, 0, 1, 8'd0, 1, 1);
        add(1, 2'd0, 8'd0, 8, 4, 1, 8'd3, 1, 1);
        add(1, 2'd0, 8'd0, 8, 4, 1, 8'd2, 1, 1);
        add(1, 2'd0, 8'd0, 8, 4, 1, 8'd1, 1, 1);
        add(1, 2'd0, 8'd0, 8, 4, 1, 8'd0, 0, 0);
        add(0, 2'd2, 8'd0, 0, 0, 1, 8'd0, 1, 1);
        add(1, 2'd0, 8'd0, 8, 4, 1, 8'd3, 1, 1);
        add(1, 2'd0, 8'd0, 2, 2, 10, 8'd3, 1, 1);
        add(1, 2'd0, 8'd0, 3, 4, 1, 8'd2, 1, 1);
        add(0, 2'd0, 8'd0, 0, 0, 1, 8'd2, 1, 1);
        add(0, 2'd3, 8'd0, 0, 0, 1, 8'd2, 1, 1);
        add(0, 2'd1, 8'd0, 0, 0, 1, 8'd0, 1, 1);
        add(1, 2'd0, 8'd0, 8, 4, 1, 8'd0, 0, 0);
        add(0, 2'd2, 8'd0, 0, 0, 1, 8'd0, 1, 1);
        add(0, 2'd3, 8'd0, 0, 0, 1, 8'd0, 1, 1);
        add(1, 2'd0, 8'd0, 8, 4, 1, 8'd0, 0, 1);
        add(0, 2'd2, 8'd0, 0, 0, 1, 8'd0, 1, 1);
        add(0, 2'd3, 8'd0, 0, 0, 1, 8'd0, 1, 1);
        add(1, 2'd0, 8'd0, 8, 4, 1, 8'd0, 0, 1);
        add(1, 2'd0, 8'd0, 8, 4, 1, 8'd0, 0, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].kind == 0) wr(vecs[i].sel, vecs[i].data);
            else repeat (vecs[i].reps) pulse(vecs[i].low, vecs[i].high);
            chk_all($sformatf("vec%0d", i), vecs[i].exp_cnt, vecs[i].exp_irq, vecs[i].exp_irqo);
        end

        // Reload write colliding with a qualified edge at counter 5.
        wr(2'd2, 8'd0);
        wr(2'd0, 8'd5);
        wr(2'd1, 8'd0);
        pulse(8, 4);
        chk_all("load5", 8'd5, 1'b1, 1'b1);
        wr(2'd0, 8'd9);
        collide(2'd1, 8'd0);
        chk_all("reload_collide", 8'd0, 1'b1, 1'b1);
        pulse(8, 4);
        chk_all("reload_after", 8'd9, 1'b1, 1'b1);

        // Latch write colliding with a reload edge: old latch is used.
        wr(2'd1, 8'd0);
        collide(2'd0, 8'd7);
        chk_all("latch_collide", 8'd9, 1'b1, 1'b1);
        pulse(8, 4);
        chk_all("latch_dec", 8'd8, 1'b1, 1'b1);
        wr(2'd1, 8'd0);
        pulse(8, 4);
        chk_all("latch_new", 8'd7, 1'b1, 1'b1);

        // Disable write colliding with a decrement to zero.
        wr(2'd0, 8'd1);
        wr(2'd1, 8'd0);
        wr(2'd3, 8'd0);
        pulse(8, 4);
        chk_all("load1", 8'd1, 1'b1, 1'b1);
        collide(2'd2, 8'd0);
        chk_all("disable_collide", 8'd0, 1'b1, 1'b1);

        // Enable write colliding with a decrement to zero.
        pulse(8, 4);
        chk_all("reload1", 8'd1, 1'b1, 1'b1);
        collide(2'd3, 8'd0);
        chk_all("enable_collide", 8'd0, 1'b1, 1'b1);

        // Full 0xFF reload and exact IRQ latency on the final clock.
        wr(2'd0, 8'hFF);
        wr(2'd1, 8'd0);
        pulse(8, 4);
        chk_all("loadFF", 8'hFF, 1'b1, 1'b1);
        repeat (254) pulse(3, 3);
        chk_all("count254", 8'd1, 1'b1, 1'b1);
        ppu_a12 = 1'b0;
        repeat (8) tick();
        ppu_a12 = 1'b1;
        repeat (3) tick();
        chk_all("zero_edge", 8'd0, 1'b1, 1'b1);
        tick();
        chk_all("irq_latency", 8'd0, 1'b0, 1'b0);

        // Asynchronous reset while pending.
        wr(2'd0, 8'd5);
        chk_all("pre_reset", 8'd0, 1'b0, 1'b0);
        reset = 1'b1;
        #1;
        chk_all("async_reset", 8'd0, 1'b1, 1'b1);
        tick();
        reset = 1'b0;
        tick();
        pulse(8, 4);
        chk_all("post_reset", 8'd0, 1'b1, 1'b1);
        wr(2'd0, 8'd2);
        pulse(8, 4);
        chk_all("post_reset_load", 8'd2, 1'b1, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
